// File: rtl/dds_pkg.sv
// ---------------------------------------------------------------------------
// dds_pkg
// Shared definitions for the DDS tuning blocks.
//   DDS_TUNE_WIDTH : default width of tuning words (phase-accumulator width)
//   sweep_state_e  : state encoding of the tune_sweep controller
// ---------------------------------------------------------------------------
package dds_pkg;

    localparam int DDS_TUNE_WIDTH = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DWELL = 2'd1,
        ST_STEP  = 2'd2,
        ST_FIN   = 2'd3
    } sweep_state_e;

endpackage

// File: rtl/dwell_cnt.sv
// ---------------------------------------------------------------------------
// dwell_cnt
// Down-counter that times how long each tuning word is held.
// Ports:
//   clk_i    : clock
//   rst_i    : synchronous active-high reset, clears the count
//   load_i   : load a new dwell length (first hold cycle follows the load)
//   len_i    : dwell length in cycles; 0 is treated as 1
//   expire_o : high in the hold cycle just before the final hold cycle
// ---------------------------------------------------------------------------
module dwell_cnt #(
    parameter int DWELL_WIDTH = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   load_i,
    input  logic [DWELL_WIDTH-1:0] len_i,
    output logic                   expire_o
);

    logic [DWELL_WIDTH-1:0] cnt_q;
    logic [DWELL_WIDTH-1:0] cnt_d;

    // The final hold cycle of a word is spent in the controller's STEP state,
    // so the counter only has to cover the len-1 cycles before it.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = (len_i == '0) ? '0 : len_i - DWELL_WIDTH'(1);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - DWELL_WIDTH'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire_o = (cnt_q == DWELL_WIDTH'(1));

endmodule

// File: rtl/tune_sweep.sv
// ---------------------------------------------------------------------------
// tune_sweep
// Frequency-sweep controller producing the tuning word for a DDS. Steps a
// registered tuning word from f_start towards f_stop by f_step, holding each
// word for max(dwell,1) cycles, either once or repeatedly.
// Ports:
//   clk         : clock, all state updates on the rising edge
//   RST         : synchronous active-high reset
//   start       : one-cycle request to begin a sweep (ignored while busy)
//   abort       : one-cycle request to stop; wins over start
//   continuous  : 1 = repeat the sweep forever, 0 = single pass
//   f_start     : first tuning word
//   f_stop      : last tuning word (never passed, never wrapped)
//   f_step      : unsigned step magnitude
//   dwell       : cycles each word is held
//   tuning_word : registered tuning word to the DDS
//   busy        : registered, high while a sweep runs
//   done        : registered one-cycle pulse after a single-pass sweep
// ---------------------------------------------------------------------------
module tune_sweep
    import dds_pkg::*;
#(
    parameter int TUNE_WIDTH  = DDS_TUNE_WIDTH,
    parameter int DWELL_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   RST,
    input  logic                   start,
    input  logic                   abort,
    input  logic                   continuous,
    input  logic [TUNE_WIDTH-1:0]  f_start,
    input  logic [TUNE_WIDTH-1:0]  f_stop,
    input  logic [TUNE_WIDTH-1:0]  f_step,
    input  logic [DWELL_WIDTH-1:0] dwell,
    output logic [TUNE_WIDTH-1:0]  tuning_word,
    output logic                   busy,
    output logic                   done
);

    sweep_state_e state_q, state_d;

    logic [TUNE_WIDTH-1:0]  word_q, word_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;

    // Sweep parameters captured on the accepted start
    logic [TUNE_WIDTH-1:0]  f_start_q, f_stop_q, f_step_q;
    logic [DWELL_WIDTH-1:0] dwell_q;
    logic                   cont_q;
    logic                   up_q;
    logic                   cap_en;

    logic                   cnt_load;
    logic [DWELL_WIDTH-1:0] cnt_len;
    logic                   cnt_expire;

    // Next word computed one bit wider so overflow and underflow are visible
    // and can be clamped to the stop word instead of wrapping.
    function automatic logic [TUNE_WIDTH-1:0] next_word(
        input logic [TUNE_WIDTH-1:0] word,
        input logic [TUNE_WIDTH-1:0] stop,
        input logic [TUNE_WIDTH-1:0] step,
        input logic                  up
    );
        logic [TUNE_WIDTH:0]   ext;
        logic [TUNE_WIDTH-1:0] res;
        ext = '0;
        if (step == '0) begin
            // A zero step would never arrive; go straight to the stop word.
            res = stop;
        end else if (up) begin
            ext = {1'b0, word} + {1'b0, step};
            res = (ext > {1'b0, stop}) ? stop : ext[TUNE_WIDTH-1:0];
        end else begin
            ext = {1'b0, word} - {1'b0, step};
            res = (ext[TUNE_WIDTH] || (ext[TUNE_WIDTH-1:0] < stop)) ? stop
                                                                     : ext[TUNE_WIDTH-1:0];
        end
        return res;
    endfunction

    // A word held for a single cycle spends that cycle in STEP; longer holds
    // spend the leading cycles in DWELL and the final one in STEP.
    function automatic sweep_state_e hold_state(input logic [DWELL_WIDTH-1:0] len);
        return (len <= DWELL_WIDTH'(1)) ? ST_STEP : ST_DWELL;
    endfunction

    dwell_cnt #(
        .DWELL_WIDTH (DWELL_WIDTH)
    ) u_dwell_cnt (
        .clk_i    (clk),
        .rst_i    (RST),
        .load_i   (cnt_load),
        .len_i    (cnt_len),
        .expire_o (cnt_expire)
    );

    always_comb begin
        state_d  = state_q;
        word_d   = word_q;
        cap_en   = 1'b0;
        cnt_load = 1'b0;
        cnt_len  = dwell_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    cap_en   = 1'b1;
                    word_d   = f_start;
                    cnt_load = 1'b1;
                    cnt_len  = dwell;
                    state_d  = hold_state(dwell);
                end
            end
            ST_DWELL: begin
                if (cnt_expire) begin
                    state_d = ST_STEP;
                end
            end
            ST_STEP: begin
                if (word_q == f_stop_q) begin
                    if (cont_q) begin
                        // Reload straight into the first word: no gap cycle.
                        word_d   = f_start_q;
                        cnt_load = 1'b1;
                        state_d  = hold_state(dwell_q);
                    end else begin
                        state_d = ST_FIN;
                    end
                end else begin
                    word_d   = next_word(word_q, f_stop_q, f_step_q, up_q);
                    cnt_load = 1'b1;
                    state_d  = hold_state(dwell_q);
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Abort overrides everything, including a start in the same cycle;
        // the word freezes at its current value.
        if (abort) begin
            state_d  = ST_IDLE;
            word_d   = word_q;
            cap_en   = 1'b0;
            cnt_load = 1'b0;
        end

        busy_d = (state_d == ST_DWELL) || (state_d == ST_STEP);
        done_d = (state_d == ST_FIN);
    end

    always_ff @(posedge clk) begin
        if (RST) begin
            state_q   <= ST_IDLE;
            word_q    <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            f_start_q <= '0;
            f_stop_q  <= '0;
            f_step_q  <= '0;
            dwell_q   <= '0;
            cont_q    <= 1'b0;
            up_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            if (cap_en) begin
                f_start_q <= f_start;
                f_stop_q  <= f_stop;
                f_step_q  <= f_step;
                dwell_q   <= dwell;
                cont_q    <= continuous;
                up_q      <= (f_stop >= f_start);
            end
        end
    end

    assign tuning_word = word_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule

// File: tb/tb_tune_sweep.sv
module tb_tune_sweep;

    localparam int TW = 16;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          RST = 1'b1;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          continuous = 1'b0;
    logic [TW-1:0] f_start = '0;
    logic [TW-1:0] f_stop = '0;
    logic [TW-1:0] f_step = '0;
    logic [DW-1:0] dwell = '0;
    logic [TW-1:0] tuning_word;
    logic          busy;
    logic          done;

    int checks = 0;
    int errors = 0;

    // Expected tuning word for each cycle of one pass
    int pass_q[$];

    always #5 clk = ~clk;

    tune_sweep #(
        .TUNE_WIDTH  (TW),
        .DWELL_WIDTH (DW)
    ) dut (
        .clk         (clk),
        .RST         (RST),
        .start       (start),
        .abort       (abort),
        .continuous  (continuous),
        .f_start     (f_start),
        .f_stop      (f_stop),
        .f_step      (f_step),
        .dwell       (dwell),
        .tuning_word (tuning_word),
        .busy        (busy),
        .done        (done)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input int w, input bit b, input bit d);
        chk({tag, ".word"}, 32'(tuning_word), w);
        chk({tag, ".busy"}, 32'(busy), 32'(b));
        chk({tag, ".done"}, 32'(done), 32'(d));
    endtask

    // Word list of one pass, straight from the sweep rules: each word held
    // max(dwell,1) times, moving by step and clamping at stop.
    task automatic build_pass(input int s, input int e, input int st, input int d);
        int n;
        int w;
        n = (d < 1) ? 1 : d;
        w = s;
        pass_q.delete();
        while (1) begin
            for (int r = 0; r < n; r++) pass_q.push_back(w);
            if (w == e) break;
            if (st == 0)     w = e;
            else if (e >= s) w = (w + st > e) ? e : w + st;
            else             w = (w - st < e) ? e : w - st;
        end
    endtask

    // Launch one sweep and follow it cycle by cycle. ncyc<0 means len+3.
    // abort_at / rst_at: cycle index (after the first output cycle) at whose
    // following edge abort+start or RST is applied; -1 disables.
    task automatic run_sweep(input int s, input int e, input int st, input int d,
                             input bit cont, input int ncyc_in,
                             input int abort_at, input int rst_at);
        int len;
        int ncyc;
        int w_exp;
        bit b_exp;
        bit d_exp;
        build_pass(s, e, st, d);
        len  = pass_q.size();
        ncyc = (ncyc_in < 0) ? len + 3 : ncyc_in;
        f_start    = TW'(s);
        f_stop     = TW'(e);
        f_step     = TW'(st);
        dwell      = DW'(d);
        continuous = cont;
        start      = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < ncyc; k++) begin
            if (k > 0) tick();
            if (cont) begin
                w_exp = pass_q[k % len]; b_exp = 1'b1; d_exp = 1'b0;
            end else if (k < len) begin
                w_exp = pass_q[k]; b_exp = 1'b1; d_exp = 1'b0;
            end else begin
                w_exp = e; b_exp = 1'b0; d_exp = (k == len);
            end
            chk_out($sformatf("sweep@%0d", k), w_exp, b_exp, d_exp);

            // Disturb the inputs; a running sweep must not notice.
            f_start    = TW'($urandom);
            f_stop     = TW'($urandom);
            f_step     = TW'($urandom);
            dwell      = DW'($urandom_range(0, 5));
            continuous = 1'($urandom);
            start      = b_exp && ($urandom_range(0, 3) == 0);

            if (k == abort_at) begin
                abort = 1'b1;
                start = 1'b1;
                tick();
                abort = 1'b0;
                start = 1'b0;
                chk_out("abort", w_exp, 1'b0, 1'b0);
                tick();
                chk_out("abort+1", w_exp, 1'b0, 1'b0);
                tick();
                chk_out("abort+2", w_exp, 1'b0, 1'b0);
                return;
            end
            if (k == rst_at) begin
                RST   = 1'b1;
                start = 1'b1;
                tick();
                RST   = 1'b0;
                start = 1'b0;
                chk_out("rst", 0, 1'b0, 1'b0);
                tick();
                chk_out("rst+1", 0, 1'b0, 1'b0);
                return;
            end
        end
        start = 1'b0;
    endtask

    initial begin
        // Reset state
        RST = 1'b1;
        start = 1'b1;
        abort = 1'b1;
        tick();
        tick();
        start = 1'b0;
        abort = 1'b0;
        chk_out("reset", 0, 1'b0, 1'b0);
        RST = 1'b0;
        tick();
        chk_out("post_reset", 0, 1'b0, 1'b0);

        // Up sweep 100..130 step 10, dwell 3
        run_sweep(100, 130, 10, 3, 1'b0, -1, -1, -1);
        // Down sweep with clamp
        run_sweep(50, 5, 20, 1, 1'b0, -1, -1, -1);
        // Overflow clamp at the top of the range
        run_sweep(32'hFFF0, 32'hFFFF, 32'h20, 2, 1'b0, -1, -1, -1);
        // Underflow clamp at the bottom of the range
        run_sweep(10, 0, 32'h8000, 1, 1'b0, -1, -1, -1);
        // Continuous 0,0,1,1,2,2... for 20 cycles, then abort
        run_sweep(0, 2, 1, 2, 1'b1, 21, 20, -1);
        // Abort in the middle of the 2nd dwell, start in the same cycle
        run_sweep(100, 130, 10, 3, 1'b0, -1, 4, -1);
        // Reset during STEP (last hold cycle of the first word), then restart
        run_sweep(100, 130, 10, 3, 1'b0, -1, -1, 2);
        run_sweep(7, 9, 1, 0, 1'b0, -1, -1, -1);
        // Zero step and one-word sweeps
        run_sweep(20, 80, 0, 2, 1'b0, -1, -1, -1);
        run_sweep(42, 42, 5, 3, 1'b0, -1, -1, -1);
        run_sweep(42, 42, 5, 1, 1'b1, 6, 5, -1);

        // Randomized sweeps
        for (int i = 0; i < 24; i++) begin
            int s, e, st, d, diff, nc, ab, rs;
            bit c;
            s = $urandom_range(0, 65535);
            e = $urandom_range(0, 65535);
            if ($urandom_range(0, 7) == 0) e = s;
            diff = (s > e) ? s - e : e - s;
            st = diff / $urandom_range(1, 6) + $urandom_range(0, 3);
            if (st > 65535) st = 65535;
            if ($urandom_range(0, 7) == 0) st = 0;
            d  = $urandom_range(0, 4);
            c  = ($urandom_range(0, 3) == 0);
            ab = -1;
            rs = -1;
            if (c) begin
                nc = $urandom_range(5, 40);
                ab = nc - 1;
            end else begin
                nc = -1;
                if ($urandom_range(0, 3) == 0) ab = $urandom_range(0, 8);
                else if ($urandom_range(0, 5) == 0) rs = $urandom_range(0, 8);
            end
            run_sweep(s, e, st, d, c, nc, ab, rs);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tune_sweep.md
TUNE_SWEEP -- requirements
Module: tune_sweep

Interface
REQ-001 SHALL have parameter TUNE_WIDTH, default 16: width of every tuning-word and step quantity; must equal the phase-accumulator tuning width.
REQ-002 SHALL have parameter DWELL_WIDTH, default 16: width of the dwell-count input.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port RST, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port start, input, 1 bit: single-cycle request to begin a sweep.
REQ-006 SHALL have port abort, input, 1 bit: single-cycle request to terminate a sweep.
REQ-007 SHALL have port continuous, input, 1 bit: when 1, the sweep repeats indefinitely; when 0, it runs a single pass.
REQ-008 SHALL have port f_start, input, TUNE_WIDTH bits: first tuning word of the sweep.
REQ-009 SHALL have port f_stop, input, TUNE_WIDTH bits: final tuning word of the sweep.
REQ-010 SHALL have port f_step, input, TUNE_WIDTH bits: unsigned step magnitude per dwell.
REQ-011 SHALL have port dwell, input, DWELL_WIDTH bits: number of cycles each word is held.
REQ-012 SHALL have port tuning_word, output, TUNE_WIDTH bits: registered word that feeds the DDS tuning_word input.
REQ-013 SHALL have port busy, output, 1 bit: high while a sweep is in progress.
REQ-014 SHALL have port done, output, 1 bit: one-cycle pulse at the end of a single-pass sweep.

Function
REQ-015 SHALL implement FSM states IDLE, DWELL, STEP and FIN.
- IDLE -> DWELL on start.
- DWELL -> STEP when the dwell count expires.
- STEP -> DWELL if the word is not at f_stop.
- STEP -> FIN if the word is at f_stop and continuous=0.
- FIN -> IDLE unconditionally.
REQ-016 SHALL capture f_start, f_stop, f_step, dwell and continuous into internal registers on the accepted start; input changes during a sweep SHALL have no effect.
REQ-017 SHALL drive tuning_word=f_start and busy=1 in the cycle after start is sampled in IDLE (latency 1).
REQ-018 SHALL hold each tuning word for exactly max(dwell,1) cycles; dwell=0 behaves as dwell=1.
REQ-019 SHALL sweep in the up direction when f_stop >= f_start, and in the down direction otherwise; direction is fixed at capture.
REQ-020 SHALL compute the next word in STEP as word±f_step at TUNE_WIDTH+1 bits, clamped to f_stop on overshoot or overflow/underflow, so tuning_word never passes f_stop and never wraps.
REQ-021 SHALL treat f_step=0 as a single jump to f_stop after the first dwell.
REQ-022 SHALL treat f_start==f_stop as a one-word sweep: dwell once on f_start, then finish or repeat.
REQ-023 SHALL, when continuous=1 and the word is at f_stop after its dwell, reload f_start with no gap cycle; done SHALL never assert in this mode.
REQ-024 SHALL, in FIN, pulse done=1 for one cycle with busy=0 and tuning_word held at f_stop.
REQ-025 SHALL ignore start while busy=1.
REQ-026 SHALL, on abort, go to IDLE in the next cycle with busy=0, done=0 and tuning_word holding its current value.
REQ-027 SHALL give abort priority when start and abort are sampled in the same cycle; the result is IDLE and no sweep begins.
REQ-028 SHALL register all outputs (no combinational input-to-output paths).

Reset
REQ-029 SHALL, with RST=1 at a clock edge, set state=IDLE, tuning_word=0, busy=0, done=0, and clear the dwell counter and captured registers.
REQ-030 SHALL let RST override start and abort and abandon any sweep in progress with no done pulse.

Structure
REQ-031 SHALL place the FSM state enum type and the default TUNE_WIDTH constant in the shared package dds_pkg.
REQ-032 SHALL implement the dwell timing as one sub-module, dwell_cnt (load, count-down, expire pulse, DWELL_WIDTH parameter).

Verification
REQ-033 SHALL cover an up sweep: f_start=100, f_stop=130, f_step=10, dwell=3 -> tuning_word shows 100,100,100,110x3,120x3,130x3; then done pulses once; busy falls with done.
REQ-034 SHALL cover a down sweep with clamp: f_start=50, f_stop=5, f_step=20, dwell=1 -> tuning_word shows 50,30,10,5; then done.
REQ-035 SHALL cover overflow: f_start=0xFFF0, f_stop=0xFFFF, f_step=0x20 -> tuning_word shows 0xFFF0, then 0xFFFF; no wrap to a low value.
REQ-036 SHALL cover continuous mode: f_start=0, f_stop=2, f_step=1, dwell=2, run for 20 cycles -> the pattern 0,0,1,1,2,2 repeats; done never asserts.
REQ-037 SHALL cover abort: abort asserted in the middle of the 2nd dwell -> busy=0 next cycle; tuning_word frozen; no done; start asserted in the same cycle as abort is ignored.
REQ-038 SHALL cover reset mid-sweep: RST asserted during STEP -> the next cycle shows tuning_word=0 and busy=0; a later start behaves per REQ-017.
